// File: rtl/digit_vote_pkg.sv
// rtl/digit_vote_pkg.sv - shared types and constants for the digit vote filter
//
// Purpose: FSM state encoding, class count, blank display code and digit width
//   shared by digit_vote_filter and digit_vote_tally.
// Ports: none (package).

package digit_vote_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SNAP   = 2'd1,
    SCAN   = 2'd2,
    DECIDE = 2'd3
  } vote_state_e;

  localparam int          NUM_CLASSES = 10;
  localparam int          DIGIT_W     = 4;
  localparam logic [15:0] BLANK_NUMS  = 16'hFFFF;

  // One-hot LED pattern for a digit; out-of-range codes give all zeros.
  function automatic logic [NUM_CLASSES-1:0] digit_onehot(input logic [DIGIT_W-1:0] d);
    logic [NUM_CLASSES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      oh[i] = (d == DIGIT_W'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/digit_vote_tally.sv
// rtl/digit_vote_tally.sv - combinational vote count for one candidate digit
//
// Purpose: counts how many valid snapshot entries hold the candidate digit.
// Ports:
//   entry_valid  in  DEPTH          per-entry valid flags
//   entry_digit  in  DEPTH*DIGIT_W  packed entry digits, entry i at [i*DIGIT_W +: DIGIT_W]
//   candidate    in  DIGIT_W        digit being counted
//   tally        out CNT_W          number of matching valid entries

module digit_vote_tally
  import digit_vote_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]         entry_valid,
  input  logic [DEPTH*DIGIT_W-1:0] entry_digit,
  input  logic [DIGIT_W-1:0]       candidate,
  output logic [CNT_W-1:0]         tally
);

  always_comb begin
    tally = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_digit[i*DIGIT_W +: DIGIT_W] == candidate)) begin
        tally = tally + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/digit_vote_filter.sv
// rtl/digit_vote_filter.sv - majority-vote filter between digit classifier and display
//
// Purpose: keeps a DEPTH-entry ring of classifier results, rescans it after every
//   legal strobe and only moves the display to a digit holding >= THRESH votes.
//   Optional feature macro: VOTE_STALE_TIMEOUT_EN (blank the display after
//   STALE_CYCLES clocks without a legal strobe).
// Ports:
//   clk          in  1   clock, posedge
//   rst_n        in  1   asynchronous active-low reset
//   clear        in  1   synchronous clear (level)
//   digit_in     in  4   classifier result, 0..9 legal
//   digit_valid  in  1   strobe qualifying digit_in
//   stable_digit out 4   accepted digit
//   stable_valid out 1   stable_digit meaningful
//   changed      out 1   one-cycle pulse when stable_digit/stable_valid change
//   nums         out 16  {4{stable_digit}} when valid, else 16'hFFFF
//   led          out 10  one-hot of stable_digit when valid, else 0

module digit_vote_filter
  import digit_vote_pkg::*;
#(
  parameter int DEPTH        = 5,
  parameter int THRESH       = 3,
  parameter int STALE_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  output logic [3:0]  stable_digit,
  output logic        stable_valid,
  output logic        changed,
  output logic [15:0] nums,
  output logic [9:0]  led
);

  localparam int                 CNT_W     = $clog2(DEPTH + 1);
  localparam int                 PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   THRESH_C  = CNT_W'(THRESH);
  localparam logic [DIGIT_W-1:0] LAST_CAND = DIGIT_W'(NUM_CLASSES - 1);

  if (DEPTH < 2 || DEPTH > 15 || THRESH < 1 || THRESH > DEPTH || STALE_CYCLES < 1) begin : g_param_check
    $error("digit_vote_filter: parameter out of range");
  end

  vote_state_e              state_q, state_d;
  logic [DEPTH-1:0]         hist_valid_q, hist_valid_d;
  logic [DEPTH*DIGIT_W-1:0] hist_digit_q, hist_digit_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic                     pending_q, pending_d;
  logic [DEPTH-1:0]         snap_valid_q, snap_valid_d;
  logic [DEPTH*DIGIT_W-1:0] snap_digit_q, snap_digit_d;
  logic [DIGIT_W-1:0]       cand_q, cand_d;
  logic [DIGIT_W-1:0]       best_q, best_d;
  logic [CNT_W-1:0]         best_cnt_q, best_cnt_d;
  logic [DIGIT_W-1:0]       stable_digit_q, stable_digit_d;
  logic                     stable_valid_q, stable_valid_d;
  logic                     changed_q, changed_d;
  logic [15:0]              nums_q, nums_d;
  logic [9:0]               led_q, led_d;
  logic [CNT_W-1:0]         tally;
  logic                     strobe_ok;
  logic                     rescan;
  logic                     stale_hit;

  assign strobe_ok = digit_valid && (digit_in < DIGIT_W'(NUM_CLASSES));
  // A strobe arriving this cycle counts as pending work, so the FSM enters SNAP
  // on the same edge that writes the history entry.
  assign rescan    = pending_q || strobe_ok;

`ifdef VOTE_STALE_TIMEOUT_EN
  localparam int                IDLE_W   = $clog2(STALE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALE_CYCLES);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (clear || strobe_ok) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign stale_hit = (idle_cnt_q == IDLE_MAX) && stable_valid_q && !strobe_ok;
`else
  assign stale_hit = 1'b0;
`endif

  digit_vote_tally #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tally (
    .entry_valid (snap_valid_q),
    .entry_digit (snap_digit_q),
    .candidate   (cand_q),
    .tally       (tally)
  );

  always_comb begin
    state_d        = state_q;
    hist_valid_d   = hist_valid_q;
    hist_digit_d   = hist_digit_q;
    wr_ptr_d       = wr_ptr_q;
    pending_d      = pending_q;
    snap_valid_d   = snap_valid_q;
    snap_digit_d   = snap_digit_q;
    cand_d         = cand_q;
    best_d         = best_q;
    best_cnt_d     = best_cnt_q;
    stable_digit_d = stable_digit_q;
    stable_valid_d = stable_valid_q;
    changed_d      = 1'b0;

    if (clear) begin
      state_d        = IDLE;
      hist_valid_d   = '0;
      wr_ptr_d       = '0;
      pending_d      = 1'b0;
      cand_d         = '0;
      best_d         = '0;
      best_cnt_d     = '0;
      stable_digit_d = '0;
      stable_valid_d = 1'b0;
      changed_d      = stable_valid_q;
    end else begin
      if (strobe_ok) begin
        hist_digit_d[wr_ptr_q*DIGIT_W +: DIGIT_W] = digit_in;
        hist_valid_d[wr_ptr_q]                    = 1'b1;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (rescan) state_d = SNAP;
        end
        SNAP: begin
          snap_valid_d = hist_valid_q;
          snap_digit_d = hist_digit_q;
          pending_d    = 1'b0;
          cand_d       = '0;
          best_d       = '0;
          best_cnt_d   = '0;
          state_d      = SCAN;
        end
        SCAN: begin
          // Strict compare: on a tie the lower digit, seen first, stays best.
          if (tally > best_cnt_q) begin
            best_d     = cand_q;
            best_cnt_d = tally;
          end
          if (cand_q == LAST_CAND) begin
            state_d = DECIDE;
          end else begin
            cand_d = cand_q + DIGIT_W'(1);
          end
        end
        DECIDE: begin
          if (best_cnt_q >= THRESH_C) begin
            stable_digit_d = best_q;
            stable_valid_d = 1'b1;
            changed_d      = !stable_valid_q || (stable_digit_q != best_q);
          end
          state_d = rescan ? SNAP : IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Applied after SNAP so a strobe landing during the copy is not lost.
      if (strobe_ok) pending_d = 1'b1;

      if (stale_hit) begin
        hist_valid_d   = '0;
        stable_valid_d = 1'b0;
        changed_d      = 1'b1;
      end
    end

    nums_d = stable_valid_d ? {4{stable_digit_d}} : BLANK_NUMS;
    led_d  = stable_valid_d ? digit_onehot(stable_digit_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      hist_valid_q   <= '0;
      hist_digit_q   <= '0;
      wr_ptr_q       <= '0;
      pending_q      <= 1'b0;
      snap_valid_q   <= '0;
      snap_digit_q   <= '0;
      cand_q         <= '0;
      best_q         <= '0;
      best_cnt_q     <= '0;
      stable_digit_q <= '0;
      stable_valid_q <= 1'b0;
      changed_q      <= 1'b0;
      nums_q         <= BLANK_NUMS;
      led_q          <= '0;
    end else begin
      state_q        <= state_d;
      hist_valid_q   <= hist_valid_d;
      hist_digit_q   <= hist_digit_d;
      wr_ptr_q       <= wr_ptr_d;
      pending_q      <= pending_d;
      snap_valid_q   <= snap_valid_d;
      snap_digit_q   <= snap_digit_d;
      cand_q         <= cand_d;
      best_q         <= best_d;
      best_cnt_q     <= best_cnt_d;
      stable_digit_q <= stable_digit_d;
      stable_valid_q <= stable_valid_d;
      changed_q      <= changed_d;
      nums_q         <= nums_d;
      led_q          <= led_d;
    end
  end

  assign stable_digit = stable_digit_q;
  assign stable_valid = stable_valid_q;
  assign changed      = changed_q;
  assign nums         = nums_q;
  assign led          = led_q;

endmodule
